// File: rtl/time_entry_ctrl.sv
// Front-panel time-entry controller: debounces the MODE/INC keys, edits a shadow H:M:S
// and hands it to the timekeeping block with a one-cycle load strobe.
module time_entry_ctrl #(
    parameter int DEB_CNT    = 4,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 2,
    parameter int TIMEOUT    = 60,
    parameter int BLINK_HALF = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick,
    input  logic       KEY_MODE,
    input  logic       KEY_INC,
    input  logic [7:0] cur_hrs,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_hrs,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] field,
    output logic       blink
);

    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam int RPT_W = $clog2(REPEAT_DLY + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);

    localparam int K_MODE = 0;
    localparam int K_INC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    state_t state_q, state_d;

    // Key pipeline, bit 0 = MODE, bit 1 = INC. Synchroniser holds raw (active-low) levels,
    // deb_q holds the debounced pressed state (1 = pressed).
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_prev_q, deb_prev_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_fire_q, rpt_fire_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;

    logic [7:0] set_hrs_q, set_hrs_d;
    logic [7:0] set_min_q, set_min_d;
    logic [7:0] set_sec_q, set_sec_d;

    logic mode_evt;
    logic inc_evt;
    logic key_evt;
    logic in_edit;
    logic tmo_expire;

    assign mode_evt = deb_q[K_MODE] & ~deb_prev_q[K_MODE];
    assign inc_evt  = (deb_q[K_INC] & ~deb_prev_q[K_INC]) | rpt_fire_q;
    assign key_evt  = mode_evt | inc_evt;
    assign in_edit  = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) ||
                      (state_q == ST_SET_SEC);

    // ------------------------------------------------------------------
    // Key synchronisation, debounce and auto-repeat
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
        sync1_d    = {KEY_INC, KEY_MODE};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        deb_cnt_d  = deb_cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (tick) begin
                if (~sync2_q[k] != deb_q[k]) begin
                    if (deb_cnt_q[k] == DEB_W'(DEB_CNT - 1)) begin
                        deb_d[k]     = ~sync2_q[k];
                        deb_cnt_d[k] = '0;
                    end else begin
                        deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
                    end
                end else begin
                    deb_cnt_d[k] = '0;
                end
            end
        end
    end

    // Repeat counter rewinds by REPEAT_PER after each firing so it never exceeds REPEAT_DLY.
    always_comb begin
        rpt_cnt_d  = rpt_cnt_q;
        rpt_fire_d = 1'b0;
        if (!deb_q[K_INC]) begin
            rpt_cnt_d = '0;
        end else if (tick) begin
            if (rpt_cnt_q == RPT_W'(REPEAT_DLY - 1)) begin
                rpt_fire_d = 1'b1;
                rpt_cnt_d  = RPT_W'(REPEAT_DLY - REPEAT_PER);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edit FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign tmo_expire = tick && in_edit && !key_evt && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (mode_evt) state_d = ST_SET_HR;
            ST_SET_HR:  if (mode_evt) state_d = ST_SET_MIN;
                        else if (tmo_expire) state_d = ST_IDLE;
            ST_SET_MIN: if (mode_evt) state_d = ST_SET_SEC;
                        else if (tmo_expire) state_d = ST_IDLE;
            ST_SET_SEC: if (mode_evt) state_d = ST_COMMIT;
                        else if (tmo_expire) state_d = ST_IDLE;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        editing = 1'b0;
        field   = 2'd0;
        unique case (state_q)
            ST_SET_HR:  begin editing = 1'b1; field = 2'd1; end
            ST_SET_MIN: begin editing = 1'b1; field = 2'd2; end
            ST_SET_SEC: begin editing = 1'b1; field = 2'd3; end
            ST_COMMIT:  load = 1'b1;
            default:    ;
        endcase
        blink = blink_q & editing;
    end

    // ------------------------------------------------------------------
    // Shadow time, timeout and blink
    // ------------------------------------------------------------------
    always_comb begin
        set_hrs_d = set_hrs_q;
        set_min_d = set_min_q;
        set_sec_d = set_sec_q;
        if (state_q == ST_IDLE && mode_evt) begin
            set_hrs_d = cur_hrs;
            set_min_d = cur_min;
            set_sec_d = cur_sec;
        end else if (in_edit && !mode_evt && inc_evt) begin
            // Compare-and-clear so out-of-range captured values also fall back to 0.
            case (state_q)
                ST_SET_HR:  set_hrs_d = (set_hrs_q >= 8'd23) ? 8'd0 : set_hrs_q + 8'd1;
                ST_SET_MIN: set_min_d = (set_min_q >= 8'd59) ? 8'd0 : set_min_q + 8'd1;
                ST_SET_SEC: set_sec_d = (set_sec_q >= 8'd59) ? 8'd0 : set_sec_q + 8'd1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!in_edit || key_evt) begin
            tmo_cnt_d = '0;
        end else if (tick) begin
            tmo_cnt_d = tmo_expire ? '0 : tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!in_edit) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            deb_q       <= 2'b00;
            deb_prev_q  <= 2'b00;
            deb_cnt_q   <= '0;
            rpt_cnt_q   <= '0;
            rpt_fire_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            set_hrs_q   <= 8'd0;
            set_min_q   <= 8'd0;
            set_sec_q   <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_fire_q  <= rpt_fire_d;
            tmo_cnt_q   <= tmo_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            set_hrs_q   <= set_hrs_d;
            set_min_q   <= set_min_d;
            set_sec_q   <= set_sec_d;
        end
    end

    assign set_hrs = set_hrs_q;
    assign set_min = set_min_q;
    assign set_sec = set_sec_q;

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Front-panel time-entry controller: the writer side of the clock's time-set interface.
- Debounces two raw push-buttons (MODE, INC) and steps an edit FSM through hours, minutes and seconds.
- Edits a shadow copy of the current time, then issues a one-cycle load strobe with the new H:M:S to the timekeeping block.
- Also drives field-select and blink outputs so the display path can flash the field being edited.

Parameters:
DEB_CNT, 4, consecutive tick samples a raw key must hold a new level before the debounced state changes
REPEAT_DLY, 8, ticks INC must stay debounced-pressed before auto-repeat starts
REPEAT_PER, 2, ticks between auto-repeat increments once repeat is active
TIMEOUT, 60, ticks with no key event in an edit state before abort to IDLE (no load)
BLINK_HALF, 1, ticks per blink half-period

Ports:
CLK  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-low reset
tick  in  1  one-CLK-wide enable pulse (2 Hz domain tick); all debounce/repeat/timeout/blink counting advances only on tick
KEY_MODE  in  1  raw button, active-low (0 = pressed), asynchronous to CLK
KEY_INC  in  1  raw button, active-low, asynchronous to CLK
cur_hrs  in  8  current clock hours, 0..23
cur_min  in  8  current clock minutes, 0..59
cur_sec  in  8  current clock seconds, 0..59
set_hrs  out  8  shadow hours
set_min  out  8  shadow minutes
set_sec  out  8  shadow seconds
load  out  1  one-CLK pulse; the clock copies set_* on this cycle
editing  out  1  high in SET_HR, SET_MIN and SET_SEC
field  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds
blink  out  1  field-flash phase; 0 when not editing

Behaviour:
- Reset (reset == 0 at posedge): state = IDLE; set_* = 0; load, editing, field, blink = 0; debounced keys = released; all counters = 0. Reset overrides every other event, including mid-edit, where the pending edit is discarded with no load.
- Synchronisation: each raw key passes a 2-flop synchroniser on every CLK.
- Debounce:
  - On tick, compare the synchronised level with the debounced level.
  - If they differ, increment that key's counter; on reaching DEB_CNT, adopt the new level and clear the counter.
  - If they are equal, clear the counter.
- Events:
  - Press event = debounced transition released -> pressed. It is a 1-CLK pulse on the CLK after the transition.
  - Release generates no event.
- Auto-repeat (INC only): while debounced-pressed, count ticks. After REPEAT_DLY ticks, issue an INC event every REPEAT_PER ticks. The counter clears on release.
- FSM: IDLE, SET_HR, SET_MIN, SET_SEC, COMMIT.
  - IDLE: MODE event captures cur_* into set_* and goes to SET_HR. INC events are ignored.
  - SET_HR: MODE -> SET_MIN. INC -> set_hrs+1, wrapping 23 -> 0.
  - SET_MIN: MODE -> SET_SEC. INC -> set_min+1, wrapping 59 -> 0.
  - SET_SEC: MODE -> COMMIT. INC -> set_sec+1, wrapping 59 -> 0.
  - COMMIT: load = 1 for exactly this one CLK, then IDLE unconditionally. Key events arriving in COMMIT are dropped.
- Shadow updates land on the CLK following the event pulse.
- MODE and INC events in the same CLK: MODE wins and INC is dropped.
- Timeout: the counter clears on any key event and on entry to an edit state, and increments on tick in edit states. On reaching TIMEOUT it returns to IDLE, load stays 0, and set_* hold their last values.
- Arithmetic: 8-bit unsigned. Wrap uses compare-and-clear, not modulo.
- Out-of-range values captured from cur_* (e.g. hrs = 30) are held as captured. The next INC on that field wraps it to 0.
- field: 1, 2 or 3 in SET_HR, SET_MIN or SET_SEC respectively; 0 otherwise.
- Blink: toggles every BLINK_HALF ticks while editing. It is forced to 0 and its counter cleared in IDLE and COMMIT.

Test Plan:
- Reset then idle: hold reset = 0 for 3 CLK, release, no keys for 100 ticks -> set_* = 0, load never asserts, field = 0, blink = 0.
- Bounce rejection: KEY_MODE low for 3 ticks then high (DEB_CNT = 4) -> no event, state stays IDLE; low for 4 ticks -> editing = 1, field = 1.
- Full edit: with cur = 23:59:58, press MODE, INC×1, MODE, INC×2, MODE, MODE -> set_* = 00:01:58 and load high for exactly 1 CLK; FSM returns to IDLE.
- Auto-repeat: in SET_MIN from 57, hold INC for 8 + 2×3 ticks after debounce -> sequence 58, 59, 0, 1, 2 (first step plus 4 repeats).
- Simultaneous and timeout: MODE and INC events on the same CLK in SET_HR -> SET_MIN with set_hrs unchanged; then 60 idle ticks -> IDLE, no load.
- Reset mid-edit: in SET_SEC, reset = 0 for 1 CLK -> IDLE, set_* = 0, load = 0.
